// File: rtl/acc_mem_arbiter_if.sv
// Bus bundle joining the CPU, the accelerator control unit and the memory port
// to the arbiter. The arbiter uses the slave view; its environment uses master.
interface acc_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 32,
  parameter int LINE_W = 512
);
  logic              cpu_rd_en;
  logic              cpu_wr_en;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wr_data;
  logic [WORD_W-1:0] cpu_rd_data;
  logic              cpu_stall;

  logic              acc_rd_en;
  logic [ADDR_W-1:0] acc_rd_addr;
  logic [LINE_W-1:0] acc_rd_data;
  logic              acc_rd_data_valid;
  logic              acc_wr_en;
  logic [ADDR_W-1:0] acc_wr_addr;
  logic [WORD_W-1:0] acc_wr_data;
  logic              acc_wr_done;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [WORD_W-1:0] mem_wr_data;
  logic [LINE_W-1:0] mem_rd_data;

  logic              listen_en;
  logic [ADDR_W-1:0] listen_addr;
  logic [WORD_W-1:0] listen_data;

  modport master (
    output cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wr_data,
    input  cpu_rd_data, cpu_stall,
    output acc_rd_en, acc_rd_addr, acc_wr_en, acc_wr_addr, acc_wr_data,
    input  acc_rd_data, acc_rd_data_valid, acc_wr_done,
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
    output mem_rd_data,
    input  listen_en, listen_addr, listen_data
  );

  modport slave (
    input  cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wr_data,
    output cpu_rd_data, cpu_stall,
    input  acc_rd_en, acc_rd_addr, acc_wr_en, acc_wr_addr, acc_wr_data,
    output acc_rd_data, acc_rd_data_valid, acc_wr_done,
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
    input  mem_rd_data,
    output listen_en, listen_addr, listen_data
  );
endinterface

// File: rtl/acc_mem_arbiter.sv
// Shares one memory port between a CPU (combinational pass-through, default owner)
// and an accelerator (line reads / word writes) with a starvation guard.
module acc_mem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int WORD_W       = 32,
  parameter int LINE_W       = 512,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  acc_mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
  localparam int LAT_W = $clog2(RD_LATENCY) + 1;

  typedef enum logic [2:0] {
    IDLE, ACC_RD, ACC_RD_WAIT, ACC_RD_RESP, ACC_WR, ACC_WR_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [LAT_W-1:0]  r_wait_cnt;
  logic [LINE_W-1:0] r_acc_rd_data;
  logic              r_acc_rd_valid;
  logic              r_acc_wr_done;
  logic              r_pipe_vld [RD_LATENCY];
  logic [3:0]        r_pipe_idx [RD_LATENCY];

  logic              w_cpu_wr;
  logic              w_cpu_rd;
  logic              w_cpu_req;
  logic              w_acc_req;
  logic              w_issue;
  logic              w_cpu_stall;
  logic              w_starved;
  logic              w_wait_done;
  logic              w_mem_rd_en;
  logic              w_mem_wr_en;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [WORD_W-1:0] w_mem_wr_data;
  logic [WORD_W-1:0] w_cpu_rd_data;

  // CPU requests are masked while in reset so every output sits at its idle value.
  assign w_cpu_wr    = bus.cpu_wr_en & rst_n;
  assign w_cpu_rd    = bus.cpu_rd_en & ~bus.cpu_wr_en & rst_n;
  assign w_cpu_req   = w_cpu_wr | w_cpu_rd;
  assign w_acc_req   = bus.acc_rd_en | bus.acc_wr_en;
  assign w_issue     = (r_state == ACC_RD) || (r_state == ACC_WR);
  assign w_cpu_stall = w_issue & w_cpu_req;
  assign w_starved   = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign w_wait_done = (r_wait_cnt == LAT_W'(RD_LATENCY - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_acc_req && (!w_cpu_req || w_starved))
          w_next = bus.acc_rd_en ? ACC_RD : ACC_WR;
      end
      ACC_RD:      w_next = ACC_RD_WAIT;
      ACC_RD_WAIT: if (w_wait_done) w_next = ACC_RD_RESP;
      ACC_RD_RESP: w_next = IDLE;
      ACC_WR:      w_next = ACC_WR_DONE;
      ACC_WR_DONE: w_next = IDLE;
      default:     w_next = IDLE;
    endcase
  end

  always_comb begin
    w_mem_rd_en   = 1'b0;
    w_mem_wr_en   = 1'b0;
    w_mem_addr    = '0;
    w_mem_wr_data = '0;
    if (r_state == ACC_RD) begin
      w_mem_rd_en = 1'b1;
      w_mem_addr  = bus.acc_rd_addr;
    end else if (r_state == ACC_WR) begin
      w_mem_wr_en   = 1'b1;
      w_mem_addr    = bus.acc_wr_addr;
      w_mem_wr_data = bus.acc_wr_data;
    end else if (w_cpu_req) begin
      w_mem_rd_en   = w_cpu_rd;
      w_mem_wr_en   = w_cpu_wr;
      w_mem_addr    = bus.cpu_addr;
      w_mem_wr_data = bus.cpu_wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_starve_cnt   <= '0;
      r_wait_cnt     <= '0;
      r_acc_rd_data  <= '0;
      r_acc_rd_valid <= 1'b0;
      r_acc_wr_done  <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_acc_rd_valid <= (w_next == ACC_RD_RESP);
      r_acc_wr_done  <= (w_next == ACC_WR_DONE);

      if (w_next == ACC_RD || w_next == ACC_WR)
        r_starve_cnt <= '0;
      else if (r_state == IDLE && w_acc_req && w_cpu_req && !w_starved)
        r_starve_cnt <= r_starve_cnt + 1'b1;

      r_wait_cnt <= (r_state == ACC_RD_WAIT) ? r_wait_cnt + 1'b1 : '0;

      if (r_state == ACC_RD_WAIT && w_wait_done)
        r_acc_rd_data <= bus.mem_rd_data;
    end
  end

  // NOTE: the read-tracking pipe is cleared on reset so no stale word is presented afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pipe_vld[i] <= 1'b0;
        r_pipe_idx[i] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= w_cpu_rd & ~w_issue;
      r_pipe_idx[0] <= bus.cpu_addr[3:0];
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_idx[i] <= r_pipe_idx[i-1];
      end
    end
  end

  always_comb begin
    w_cpu_rd_data = '0;
    if (r_pipe_vld[RD_LATENCY-1])
      w_cpu_rd_data = bus.mem_rd_data[int'(r_pipe_idx[RD_LATENCY-1]) * WORD_W +: WORD_W];
  end

  assign bus.cpu_stall         = w_cpu_stall;
  assign bus.cpu_rd_data       = w_cpu_rd_data;
  assign bus.acc_rd_data       = r_acc_rd_data;
  assign bus.acc_rd_data_valid = r_acc_rd_valid;
  assign bus.acc_wr_done       = r_acc_wr_done;
  assign bus.mem_addr          = w_mem_addr;
  assign bus.mem_rd_en         = w_mem_rd_en;
  assign bus.mem_wr_en         = w_mem_wr_en;
  assign bus.mem_wr_data       = w_mem_wr_data;

  // Only CPU writes feed the snoop port; accelerator writes never reach it.
  assign bus.listen_en   = w_cpu_wr & ~w_cpu_stall;
  assign bus.listen_addr = (w_cpu_wr & ~w_cpu_stall) ? bus.cpu_addr    : '0;
  assign bus.listen_data = (w_cpu_wr & ~w_cpu_stall) ? bus.cpu_wr_data : '0;
endmodule
